if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Pipeline register between instruction fetch and decode in the Antares-R2 processor.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and buffers up to two entries in a main register plus a skid register.
- Presents the decoded instruction fields to decode; the 17-bit immediate field feeds the sign extender there.
- Supports stall via backpressure and flush on branch/jump redirect.

Parameters:
- DATA_W, 32, instruction width in bits.
- PC_W, 32, program counter width in bits.
- NOP_INSTR, 32'h0000_0000, instruction value presented while out_valid=0 and after flush.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  discard all buffered and incoming entries this cycle.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  stage can accept; registered (skid entry empty).
- in_instr  input  DATA_W  fetched instruction.
- in_pc  input  PC_W  address of in_instr.
- out_valid  output  1  main entry holds a valid instruction.
- out_ready  input  1  decode consumes the main entry this cycle.
- out_instr  output  DATA_W  main entry instruction (NOP_INSTR when not valid).
- out_pc  output  PC_W  main entry PC (0 when not valid).
- out_opcode  output  5  out_instr[31:27].
- out_rd  output  5  out_instr[26:22].
- out_rs  output  5  out_instr[21:17].
- out_rt  output  5  out_instr[16:12] (R-type second source).
- out_imm  output  17  out_instr[16:0], raw, unextended.

Behaviour:
- Reset (rst_n=0, asynchronous): main and skid valid=0; out_valid=0; in_ready=1; out_instr=NOP_INSTR; out_pc=0; all field outputs are slices of NOP_INSTR. Reset deasserted mid-stream: first accept occurs on the first edge with rst_n=1.
- Field outputs are pure slices of the main instruction register; they add no latency.
- Accept: in_fire = in_valid & in_ready. Consume: out_fire = out_valid & out_ready.
- Latency: an instruction accepted at edge N appears on out_* after edge N (1 cycle) when the main entry is empty or consumed at the same edge.
- Occupancy states: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
- EMPTY: in_fire -> ONE.
- ONE:
  - in_fire & out_fire -> ONE; main takes the new entry.
  - in_fire only -> FULL; new entry goes to skid, in_ready drops next cycle.
  - out_fire only -> EMPTY.
- FULL (in_ready=0):
  - out_fire -> ONE; skid moves to main and in_ready rises next cycle.
  - otherwise hold.
- Ordering is strictly FIFO; no entry is duplicated or dropped except on flush.
- Flush has priority over every other event in the same cycle:
  - both valids clear; the incoming in_valid beat is dropped even if in_ready=1; any out_fire in that cycle is ignored by this stage.
  - next cycle: EMPTY, out_instr=NOP_INSTR, out_pc=0, in_ready=1.
- Invalid entries drive NOP_INSTR and PC 0, so downstream decode sees a bubble.
- in_ready depends only on registered state, never combinationally on out_ready.
- Simultaneous in_fire and out_fire in FULL is impossible because in_ready=0.

Decomposition:
- Shared package antares_pkg holds:
  - field bit-position constants: OPCODE_MSB/LSB, RD, RS, RT, IMM_MSB=16 / IMM_LSB=0;
  - IMM_W=17;
  - NOP_INSTR.
- Decode and the sign extender use the same constants.
- One natural sub-module: skid_buffer, a generic 2-entry valid/ready register with flush, parameterised by payload width (DATA_W+PC_W). if_id_stage wraps it and adds the field slicing and NOP substitution.

Test Plan:
1. Reset then streaming: assert rst_n=0 mid-cycle, then feed instr 0x2A40_1234 at pc 0x10 with out_ready=1 -> in_ready=1 during reset; one cycle later out_valid=1, out_opcode=5, out_rd=9, out_rs=0, out_imm=0x01234, out_pc=0x10; back-to-back stream yields one output per cycle.
2. Backpressure fill: out_ready=0, push A(pc 0x0), B(pc 0x4) -> after the second edge in_ready=0 and out shows A; C held off; raise out_ready -> outputs A, B, C in order, no loss.
3. Simultaneous accept/consume in ONE: main=A, in_valid with B and out_ready=1 -> next cycle out=B, state ONE, in_ready=1.
4. Flush while FULL with in_valid=1 and out_ready=1 -> next cycle out_valid=0, out_instr=0x0000_0000, out_pc=0, in_ready=1; the incoming beat never appears.
5. Immediate boundary: instr with [16:0]=0x1FFFF and with 0x10000 -> out_imm=0x1FFFF and 0x10000 exactly, no extension.
6. Random valid/ready toggling over 1000 cycles against a FIFO scoreboard -> order preserved and in_ready never combinationally tracks out_ready.

Source files
------------

// File: rtl/antares_pkg.sv
// rtl/antares_pkg.sv - shared Antares-R2 instruction field layout and pipeline types
package antares_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RD_MSB     = 26;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 17;
    localparam int RT_MSB     = 16;
    localparam int RT_LSB     = 12;
    localparam int IMM_MSB    = 16;
    localparam int IMM_LSB    = 0;

    localparam int REG_W = 5;
    localparam int IMM_W = IMM_MSB - IMM_LSB + 1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Occupancy of a two-entry main + skid register pair
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - generic 2-entry valid/ready register with flush
module skid_buffer
    import antares_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_state_t   state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         in_fire;
    logic         out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // Occupancy FSM; handshake flags are registered so in_ready never follows out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OCC_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_q      <= in_data;
                        state       <= OCC_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q     <= in_data;
                        state      <= OCC_FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state       <= OCC_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state      <= OCC_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= OCC_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch-to-decode pipeline register with field slicing and bubble insertion
module if_id_stage
#(
    parameter int                DATA_W    = 32,
    parameter int                PC_W      = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = antares_pkg::NOP_INSTR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_instr,
    input  logic [PC_W-1:0]               in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_instr,
    output logic [PC_W-1:0]               out_pc,
    output logic [antares_pkg::REG_W-1:0] out_opcode,
    output logic [antares_pkg::REG_W-1:0] out_rd,
    output logic [antares_pkg::REG_W-1:0] out_rs,
    output logic [antares_pkg::REG_W-1:0] out_rt,
    output logic [antares_pkg::IMM_W-1:0] out_imm
);

    import antares_pkg::*;

    logic [DATA_W+PC_W-1:0] main_data;
    logic                   main_valid;

    skid_buffer #(
        .W (DATA_W + PC_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_pc, in_instr}),
        .out_valid (main_valid),
        .out_ready (out_ready),
        .out_data  (main_data)
    );

    // Empty main entry is presented as a bubble so decode never sees stale data
    always_comb begin
        out_valid = main_valid;
        out_instr = main_valid ? main_data[DATA_W-1:0] : NOP_INSTR;
        out_pc    = main_valid ? main_data[DATA_W+PC_W-1:DATA_W] : '0;
    end

    assign out_opcode = out_instr[OPCODE_MSB:OPCODE_LSB];
    assign out_rd     = out_instr[RD_MSB:RD_LSB];
    assign out_rs     = out_instr[RS_MSB:RS_LSB];
    assign out_rt     = out_instr[RT_MSB:RT_LSB];
    assign out_imm    = out_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [4:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [16:0] out_imm;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sbq[$];
    logic [63:0] exp_beat;

    if_id_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_imm    (out_imm)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p, input logic r);
        in_valid  = v;
        in_instr  = i;
        in_pc     = p;
        out_ready = r;
    endtask

    // Advance one rising edge; beats the DUT accepts at that edge enter the scoreboard
    task automatic step();
        @(negedge clk);
        if (in_valid && in_ready && !flush && rst_n)
            sbq.push_back({in_pc, in_instr});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        #2 rst_n = 1'b0;
        #1;
        sbq.delete();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b ready=%b instr=%h pc=%h, want 0 1 00000000 00000000",
                     out_valid, in_ready, out_instr, out_pc);
        end
        drive(1'b1, 32'h2A40_1234, 32'h10, 1'b1);
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: ready=%b valid=%b, want 1 0", in_ready, out_valid);
        end
        rst_n = 1'b1;
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_opcode !== 5'd5 || out_rd !== 5'd9 || out_rs !== 5'd0 ||
            out_imm !== 17'h01234 || out_pc !== 32'h10) begin
            n_bad++;
            $display("FAIL first_beat: v=%b op=%0d rd=%0d rs=%0d imm=%h pc=%h, want 1 5 9 0 01234 10",
                     out_valid, out_opcode, out_rd, out_rs, out_imm, out_pc);
        end
    endtask

    task automatic test_stream();
        int pops = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 32'hA000_0000 + i, 32'h100 + 4 * i, 1'b1);
            if (i >= 1 && i <= 8) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                pops++;
                exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
                n_cmp++;
                if ({out_pc, out_instr} !== exp_beat) begin
                    n_bad++;
                    $display("FAIL stream_data: got %h want %h", {out_pc, out_instr}, exp_beat);
                end
            end
            step();
        end
        n_cmp++;
        if (pops != 9 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_count: got %0d outputs valid=%b, want 9 0", pops, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        logic sent;
        drive(1'b1, 32'h1111_1111, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h2222_2222, 32'h4, 1'b0);
        step();
        drive(1'b1, 32'h3333_3333, 32'h8, 1'b0);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h1111_1111) begin
            n_bad++;
            $display("FAIL bp_full: ready=%b valid=%b instr=%h, want 0 1 11111111",
                     in_ready, out_valid, out_instr);
        end
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || out_instr !== 32'h1111_1111) begin
            n_bad++;
            $display("FAIL bp_hold: ready=%b instr=%h, want 0 11111111", in_ready, out_instr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_ready) begin
                pops++;
                exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
                n_cmp++;
                if ({out_pc, out_instr} !== exp_beat) begin
                    n_bad++;
                    $display("FAIL bp_order: got %h want %h", {out_pc, out_instr}, exp_beat);
                end
            end
            sent = in_valid && in_ready;
            step();
            if (sent) in_valid = 1'b0;
        end
        n_cmp++;
        if (pops != 3 || sbq.size() != 0) begin
            n_bad++;
            $display("FAIL bp_count: got %0d outputs, %0d left, want 3 0", pops, sbq.size());
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 32'h4444_4444, 32'h20, 1'b0);
        step();
        drive(1'b1, 32'h5555_5555, 32'h24, 1'b1);
        exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
        n_cmp++;
        if ({out_pc, out_instr} !== exp_beat || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_a: got %h v=%b want %h", {out_pc, out_instr}, out_valid, exp_beat);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
        n_cmp++;
        if ({out_pc, out_instr} !== exp_beat || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_b: got %h v=%b rdy=%b want %h 1 1",
                     {out_pc, out_instr}, out_valid, in_ready, exp_beat);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h6666_6666, 32'h30, 1'b0);
        step();
        drive(1'b1, 32'h7777_7777, 32'h34, 1'b0);
        step();
        drive(1'b1, 32'h8888_8888, 32'h38, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        sbq.delete();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_full: v=%b instr=%h pc=%h rdy=%b, want 0 00000000 00000000 1",
                     out_valid, out_instr, out_pc, in_ready);
        end
        drive(1'b1, 32'h9999_9999, 32'h40, 1'b0);
        step();
        drive(1'b1, 32'hAAAA_AAAA, 32'h44, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        sbq.delete();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_one_drop: v=%b instr=%h rdy=%b, want 0 00000000 1",
                     out_valid, out_instr, in_ready);
        end
    endtask

    task automatic test_imm();
        drive(1'b1, 32'hFFFF_FFFF, 32'h50, 1'b1);
        step();
        drive(1'b1, 32'h0001_0000, 32'h54, 1'b1);
        n_cmp++;
        if (out_imm !== 17'h1FFFF || out_rt !== 5'h1F) begin
            n_bad++;
            $display("FAIL imm_max: imm=%h rt=%h, want 1ffff 1f", out_imm, out_rt);
        end
        exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        n_cmp++;
        if (out_imm !== 17'h10000 || out_rt !== 5'h10 || out_opcode !== 5'd0) begin
            n_bad++;
            $display("FAIL imm_msb: imm=%h rt=%h op=%h, want 10000 10 0", out_imm, out_rt, out_opcode);
        end
        exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
        n_cmp++;
        if ({out_pc, out_instr} !== exp_beat) begin
            n_bad++;
            $display("FAIL imm_data: got %h want %h", {out_pc, out_instr}, exp_beat);
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] rp = 32'h1000;
        logic        acc;
        logic        rdy_before;
        in_valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_instr = $urandom;
                in_pc    = rp;
                rp       = rp + 32'd4;
            end
            out_ready = 1'($urandom_range(0, 1));
            n_cmp++;
            if (in_ready !== (sbq.size() < 2) || out_valid !== (sbq.size() > 0)) begin
                n_bad++;
                $display("FAIL rand_occ[%0d]: rdy=%b v=%b with %0d held", c, in_ready, out_valid, sbq.size());
            end
            rdy_before = in_ready;
            out_ready  = ~out_ready;
            #1;
            n_cmp++;
            if (in_ready !== rdy_before) begin
                n_bad++;
                $display("FAIL rand_ready_comb[%0d]: got %b want %b", c, in_ready, rdy_before);
            end
            out_ready = ~out_ready;
            #1;
            if (out_valid && out_ready) begin
                exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
                n_cmp++;
                if ({out_pc, out_instr} !== exp_beat) begin
                    n_bad++;
                    $display("FAIL rand_data[%0d]: got %h want %h", c, {out_pc, out_instr}, exp_beat);
                end
            end
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (out_valid) begin
                exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
                n_cmp++;
                if ({out_pc, out_instr} !== exp_beat) begin
                    n_bad++;
                    $display("FAIL rand_drain: got %h want %h", {out_pc, out_instr}, exp_beat);
                end
            end
            step();
        end
        n_cmp++;
        if (sbq.size() != 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_final: %0d beats lost, valid=%b", sbq.size(), out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_imm();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
